multiport_burst_line_adapter: RTL

//  Bridges NUM_PORTS cache-side line ports (e.g. I$ and D$ on the DFP side) to a single

---
 rtl/line_adapter_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/multiport_burst_line_adapter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/line_adapter_pkg.sv
// Shared types and sizing helpers for the burst line adapter.
package line_adapter_pkg;

    typedef logic [2:0] adapter_state_t;

    localparam adapter_state_t ST_IDLE     = 3'd0;
    localparam adapter_state_t ST_RD_CMD   = 3'd1;
    localparam adapter_state_t ST_RD_DATA  = 3'd2;
    localparam adapter_state_t ST_WR_BURST = 3'd3;
    localparam adapter_state_t ST_RESP     = 3'd4;

    function automatic int beats(input int line_w, input int beat_w);
        return line_w / beat_w;
    endfunction

    function automatic int offset_bits(input int line_w);
        return $clog2(line_w / 8);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first requester at or after the pointer.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             grant_update,
    input  logic [IDX_W-1:0] done_idx,
    output logic [N-1:0]     grant
);

    logic [IDX_W-1:0] ptr_q;
    logic             found;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (grant_update) begin
            ptr_q <= (done_idx == IDX_W'(N - 1)) ? '0 : done_idx + 1'b1;
        end
    end

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr_q) + k) % N]) begin
                grant[(int'(ptr_q) + k) % N] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiport_burst_line_adapter.sv
// Arbitrates whole-line requests from several ports onto one beat-serial burst memory port.
import line_adapter_pkg::*;

module multiport_burst_line_adapter #(
    parameter int NUM_PORTS = 2,
    parameter int LINE_W    = 256,
    parameter int BEAT_W    = 64,
    parameter int ADDR_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*ADDR_W-1:0] dfp_addr,
    input  logic [NUM_PORTS-1:0]        dfp_read,
    input  logic [NUM_PORTS-1:0]        dfp_write,
    input  logic [NUM_PORTS*LINE_W-1:0] dfp_wdata,
    output logic [NUM_PORTS*LINE_W-1:0] dfp_rdata,
    output logic [NUM_PORTS-1:0]        dfp_resp,
    input  logic                        bmem_ready,
    output logic [ADDR_W-1:0]           bmem_addr,
    output logic                        bmem_read,
    output logic                        bmem_write,
    output logic [BEAT_W-1:0]           bmem_wdata,
    input  logic [BEAT_W-1:0]           bmem_rdata,
    input  logic                        bmem_rvalid
);

    localparam int BEATS = beats(LINE_W, BEAT_W);
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF   = offset_bits(LINE_W);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF;

    adapter_state_t    state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic [IDX_W-1:0]  grant_idx_q, arb_idx;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q, line_q, line_next;
    logic [LINE_W-1:0] rdata_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] req, arb_grant;
    logic              last_beat;

    assign req       = dfp_read | dfp_write;
    assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));

    rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant_update (state_q == ST_RESP),
        .done_idx     (grant_idx_q),
        .grant        (arb_grant)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (arb_grant[i]) arb_idx = IDX_W'(i);
        end
    end

    always_comb begin
        line_next = line_q;
        line_next[beat_cnt_q*BEAT_W +: BEAT_W] = bmem_rdata;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (|req) state_d = dfp_write[arb_idx] ? ST_WR_BURST : ST_RD_CMD;
            ST_RD_CMD:   if (bmem_ready) state_d = ST_RD_DATA;
            ST_RD_DATA:  if (bmem_rvalid && last_beat) state_d = ST_RESP;
            ST_WR_BURST: if (bmem_ready && last_beat) state_d = ST_RESP;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            grant_idx_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            line_q      <= '0;
            for (int i = 0; i < NUM_PORTS; i++) rdata_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        grant_idx_q <= arb_idx;
                        addr_q      <= dfp_addr[arb_idx*ADDR_W +: ADDR_W] & ADDR_MASK;
                        wdata_q     <= dfp_wdata[arb_idx*LINE_W +: LINE_W];
                        beat_cnt_q  <= '0;
                    end
                end
                ST_RD_DATA: begin
                    if (bmem_rvalid) begin
                        line_q <= line_next;
                        if (last_beat) rdata_q[grant_idx_q] <= line_next;
                        else           beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                ST_WR_BURST: begin
                    if (bmem_ready && !last_beat) beat_cnt_q <= beat_cnt_q + 1'b1;
                end
                ST_RESP: beat_cnt_q <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        bmem_read  = (state_q == ST_RD_CMD);
        bmem_write = (state_q == ST_WR_BURST);
        bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
        bmem_wdata = bmem_write ? wdata_q[beat_cnt_q*BEAT_W +: BEAT_W] : '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            dfp_resp[i] = (state_q == ST_RESP) && (grant_idx_q == IDX_W'(i));
            dfp_rdata[i*LINE_W +: LINE_W] = rdata_q[i];
        end
    end

    // A port raising read and write together is a protocol violation; it is serviced as a write.
    assert property (@(posedge clk) disable iff (!rst) !(|(dfp_read & dfp_write)));

endmodule
